custom_result_stage: RTL and testbench



---
 rtl/custom_result_stage.sv | 138 +++++++++++++
 tb/tb_custom_result_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/custom_result_stage.sv
// In-order result buffer driving the CV-X-IF result channel; kills mark entries for silent drop.
// Optional same-cycle bypass when empty: define CUSTOM_RESULT_BYPASS_EN.
module custom_result_stage #(
    parameter int DEPTH      = 4,
    parameter int X_ID_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic [31:0]           ex_data_i,
    input  logic [4:0]            ex_rd_i,
    input  logic [X_ID_WIDTH-1:0] ex_id_i,
    input  logic                  ex_we_i,
    input  logic                  commit_valid_i,
    input  logic [X_ID_WIDTH-1:0] commit_id_i,
    input  logic                  commit_kill_i,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [31:0]           result_data_o,
    output logic [4:0]            result_rd_o,
    output logic [X_ID_WIDTH-1:0] result_id_o,
    output logic                  result_we_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]           data_q   [DEPTH];
    logic [4:0]            rd_q     [DEPTH];
    logic [X_ID_WIDTH-1:0] id_q     [DEPTH];
    logic                  we_q     [DEPTH];
    logic [DEPTH-1:0]      killed_q;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic             empty;
    logic             kill_req;
    logic             inc_kill;
    logic             fifo_valid;
    logic             push;
    logic             write;
    logic             pop;
    logic             byp_valid;
    logic             byp_drop;
    logic [DEPTH-1:0] kill_hit;

    assign empty      = (count_q == '0);
    assign ex_ready_o = (count_q != CNT_W'(DEPTH));
    assign kill_req   = commit_valid_i && commit_kill_i;
    assign inc_kill   = kill_req && (commit_id_i == ex_id_i);
    assign fifo_valid = !empty && !killed_q[rptr_q];
    assign push       = ex_valid_i && ex_ready_o;

`ifdef CUSTOM_RESULT_BYPASS_EN
    assign byp_valid = empty && ex_valid_i && !inc_kill;
    assign byp_drop  = empty && inc_kill;
`else
    assign byp_valid = 1'b0;
    assign byp_drop  = 1'b0;
`endif

    // A bypassed result that the core takes immediately never occupies a slot.
    assign write = push && !byp_drop && !(byp_valid && result_ready_i);
    // Killed heads are dropped without a handshake, costing one bubble.
    assign pop   = (fifo_valid && result_ready_i) || (!empty && killed_q[rptr_q]);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            kill_hit[i] = kill_req && (id_q[i] == commit_id_i)
                          && !(fifo_valid && (PTR_W'(i) == rptr_q));
        end
    end

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (write) wptr_d = wptr_q + PTR_W'(1);
        if (pop)   rptr_d = rptr_q + PTR_W'(1);
        case ({write, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        result_valid_o = 1'b0;
        result_data_o  = '0;
        result_rd_o    = '0;
        result_id_o    = '0;
        result_we_o    = 1'b0;
        if (fifo_valid) begin
            result_valid_o = 1'b1;
            result_data_o  = data_q[rptr_q];
            result_rd_o    = rd_q[rptr_q];
            result_id_o    = id_q[rptr_q];
            result_we_o    = we_q[rptr_q];
        end else if (byp_valid) begin
            result_valid_o = 1'b1;
            result_data_o  = ex_data_i;
            result_rd_o    = ex_rd_i;
            result_id_o    = ex_id_i;
            result_we_o    = ex_we_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q   <= '0;
            wptr_q   <= '0;
            count_q  <= '0;
            killed_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                rd_q[i]   <= '0;
                id_q[i]   <= '0;
                we_q[i]   <= 1'b0;
            end
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (write && (PTR_W'(i) == wptr_q)) begin
                    data_q[i]   <= ex_data_i;
                    rd_q[i]     <= ex_rd_i;
                    id_q[i]     <= ex_id_i;
                    we_q[i]     <= ex_we_i;
                    killed_q[i] <= inc_kill;
                end else if (kill_hit[i]) begin
                    killed_q[i] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_custom_result_stage.sv
// Directed bench for custom_result_stage in its default (no bypass) build.
module tb_custom_result_stage;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ex_valid_i, ex_ready_o, ex_we_i;
    logic [31:0] ex_data_i;
    logic [4:0]  ex_rd_i;
    logic [3:0]  ex_id_i;
    logic        commit_valid_i, commit_kill_i;
    logic [3:0]  commit_id_i;
    logic        result_valid_o, result_ready_i, result_we_o;
    logic [31:0] result_data_o;
    logic [4:0]  result_rd_o;
    logic [3:0]  result_id_o;

    int checks   = 0;
    int failures = 0;

    custom_result_stage #(.DEPTH(4), .X_ID_WIDTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_data_i(ex_data_i),
        .ex_rd_i(ex_rd_i), .ex_id_i(ex_id_i), .ex_we_i(ex_we_i),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_data_o(result_data_o), .result_rd_o(result_rd_o),
        .result_id_o(result_id_o), .result_we_o(result_we_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] id, input logic [31:0] data);
        ex_valid_i = v;
        ex_id_i    = id;
        ex_data_i  = data;
        ex_rd_i    = 5'd5;
        ex_we_i    = 1'b1;
    endtask

    int q[$];
    int cnt;
    int next_id;
    logic exp_rdy, exp_vld;

    initial begin
        rst_ni = 1'b0;
        drive(1'b0, 4'd0, 32'd0);
        commit_valid_i = 1'b0; commit_kill_i = 1'b0; commit_id_i = '0;
        result_ready_i = 1'b0;
        #2;
        chk("reset_ex_ready", ex_ready_o, 1);
        chk("reset_valid", result_valid_o, 0);
        chk("reset_data", result_data_o, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        step();
        chk("post_reset_ex_ready", ex_ready_o, 1);

        // single push, latency one cycle
        drive(1'b1, 4'd1, 32'h4);
        result_ready_i = 1'b1;
        chk("single_no_bypass", result_valid_o, 0);
        step();
        drive(1'b0, 4'd0, 32'd0);
        chk("single_valid", result_valid_o, 1);
        chk("single_data", result_data_o, 32'h4);
        chk("single_rd", result_rd_o, 5);
        chk("single_id", result_id_o, 1);
        chk("single_we", result_we_o, 1);
        step();
        chk("single_one_cycle", result_valid_o, 0);
        chk("single_zero_data", result_data_o, 0);

        // backpressure fill
        result_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 4'(k), 32'h100 + 32'(k));
            chk("fill_ex_ready", ex_ready_o, (k < 4) ? 1 : 0);
            step();
        end
        drive(1'b0, 4'd0, 32'd0);
        chk("full_ex_ready", ex_ready_o, 0);
        step();
        chk("stall_valid", result_valid_o, 1);
        chk("stall_id", result_id_o, 0);
        chk("stall_data", result_data_o, 32'h100);
        result_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_valid", result_valid_o, 1);
            chk("drain_id", result_id_o, k);
            chk("drain_data", result_data_o, 32'h100 + k);
            step();
        end
        chk("drained_valid", result_valid_o, 0);
        chk("drained_ex_ready", ex_ready_o, 1);

        // kill a buffered entry
        result_ready_i = 1'b0;
        for (int k = 2; k < 5; k++) begin
            drive(1'b1, 4'(k), 32'h200 + 32'(k));
            step();
        end
        drive(1'b0, 4'd0, 32'd0);
        commit_valid_i = 1'b1; commit_kill_i = 1'b1; commit_id_i = 4'd3;
        step();
        commit_valid_i = 1'b0; commit_kill_i = 1'b0;
        result_ready_i = 1'b1;
        chk("kill_head_id", result_id_o, 2);
        chk("kill_head_valid", result_valid_o, 1);
        step();
        chk("kill_bubble", result_valid_o, 0);
        chk("kill_bubble_id", result_id_o, 0);
        step();
        chk("kill_next_valid", result_valid_o, 1);
        chk("kill_next_id", result_id_o, 4);
        chk("kill_next_data", result_data_o, 32'h204);
        step();
        chk("kill_empty", result_valid_o, 0);

        // kill of presented head is ignored
        result_ready_i = 1'b0;
        drive(1'b1, 4'd2, 32'hAA);
        step();
        drive(1'b0, 4'd0, 32'd0);
        commit_valid_i = 1'b1; commit_kill_i = 1'b1; commit_id_i = 4'd2;
        step();
        commit_valid_i = 1'b0; commit_kill_i = 1'b0;
        chk("head_kill_valid", result_valid_o, 1);
        chk("head_kill_id", result_id_o, 2);
        chk("head_kill_data", result_data_o, 32'hAA);
        result_ready_i = 1'b1;
        step();
        chk("head_kill_done", result_valid_o, 0);

        // stream ids 0..7 through a full buffer, modelled by a queue
        result_ready_i = 1'b0;
        q.delete();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'(k), 32'h300 + 32'(k));
            q.push_back(k);
            step();
        end
        cnt = 4;
        next_id = 4;
        result_ready_i = 1'b1;
        for (int c = 0; c < 20 && (cnt != 0 || next_id < 8); c++) begin
            drive(next_id < 8, 4'(next_id), 32'h300 + 32'(next_id));
            exp_rdy = (cnt != 4);
            exp_vld = (cnt != 0);
            chk("stream_ex_ready", ex_ready_o, exp_rdy);
            chk("stream_valid", result_valid_o, exp_vld);
            if (exp_vld) begin
                chk("stream_id", result_id_o, q[0]);
                chk("stream_data", result_data_o, 32'h300 + q[0]);
            end
            step();
            if (exp_vld) begin
                void'(q.pop_front());
                cnt--;
            end
            if (next_id < 8 && exp_rdy) begin
                q.push_back(next_id);
                next_id++;
                cnt++;
            end
        end
        drive(1'b0, 4'd0, 32'd0);
        chk("stream_all_pushed", next_id, 8);
        chk("stream_drained", result_valid_o, 0);

        // reset mid-stream
        result_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'(k + 10), 32'h400 + 32'(k));
            step();
        end
        drive(1'b0, 4'd0, 32'd0);
        chk("pre_reset_valid", result_valid_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("midreset_valid", result_valid_o, 0);
        chk("midreset_ex_ready", ex_ready_o, 1);
        step();
        rst_ni = 1'b1;
        drive(1'b1, 4'd9, 32'h99);
        step();
        drive(1'b0, 4'd0, 32'd0);
        chk("after_reset_valid", result_valid_o, 1);
        chk("after_reset_id", result_id_o, 9);
        chk("after_reset_data", result_data_o, 32'h99);
        result_ready_i = 1'b1;
        step();
        chk("after_reset_empty", result_valid_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
